// File: rtl/bp_common_pkg.sv
// Shared definitions for the stall-profiling block.
//   bp_stall_prof_state_e : controller FSM states
//   stall_idx_*           : counter-index map (reason counters, then commit, then cycle)
package bp_common_pkg;

    typedef enum logic [1:0] {
        e_run   = 2'd0,
        e_dump  = 2'd1,
        e_clear = 2'd2
    } bp_stall_prof_state_e;

    localparam int unsigned stall_idx_unknown_gp = 0;

    // Commit and cycle counters sit directly above the reason counters.
    function automatic int unsigned stall_idx_commit(input int unsigned num_reasons);
        return num_reasons;
    endfunction

    function automatic int unsigned stall_idx_cycle(input int unsigned num_reasons);
        return num_reasons + 1;
    endfunction

endpackage

// File: rtl/bp_nonsynth_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk_i, reset_n_i : clock, synchronous active-low reset
//   clear_i          : zero the count (wins over en_i)
//   en_i             : increment by one unless already at all-ones
//   count_o          : current count
module bp_nonsynth_sat_counter #(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               clear_i,
    input  logic               en_i,
    output logic [width_p-1:0] count_o
);

    logic [width_p-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clear_i)                      count_d = '0;
        else if (en_i && (count_q != '1)) count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) count_q <= '0;
        else            count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/bsg_priority_encode.sv
// Priority encoder.
//   i      : request vector
//   addr_o : index of the winning set bit (0 when none set)
//   v_o    : any bit of i set
// lo_to_hi_p=0 gives priority to the highest set index.
module bsg_priority_encode #(
    parameter int width_p     = 1,
    parameter bit lo_to_hi_p  = 1'b0,
    localparam int lg_width_lp = (width_p > 1) ? $clog2(width_p) : 1
) (
    input  logic [width_p-1:0]     i,
    output logic [lg_width_lp-1:0] addr_o,
    output logic                   v_o
);

    always_comb begin
        addr_o = '0;
        v_o    = |i;
        // The last match in scan order wins, so scan toward the priority end.
        if (lo_to_hi_p) begin
            for (int k = width_p - 1; k >= 0; k--) begin
                if (i[k]) addr_o = lg_width_lp'(k);
            end
        end else begin
            for (int k = 0; k < width_p; k++) begin
                if (i[k]) addr_o = lg_width_lp'(k);
            end
        end
    end

endmodule

// File: rtl/bp_nonsynth_stall_profile_ctrl.sv
// Stall-cause profiler: counts, per cycle, either a commit or the dominant
// stall reason, plus total cycles, and streams the counters out on request.
//   clk_i, reset_n_i        : clock, synchronous active-low reset
//   commit_v_i              : instruction retired this cycle
//   stall_reason_i          : multi-hot stall causes (ignored on commit)
//   clear_i                 : zero all counters
//   dump_i                  : stream all counters, idx 0 .. num_reasons_p+1
//   dump_v_o/dump_ready_i   : beat handshake
//   dump_idx_o/dump_data_o  : beat index / counter value (data 0 when not valid)
//   busy_o                  : controller not counting
module bp_nonsynth_stall_profile_ctrl
    import bp_common_pkg::*;
#(
    parameter int num_reasons_p = 10,
    parameter int cnt_width_p   = 32,
    localparam int idx_width_lp = $clog2(num_reasons_p + 2)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     commit_v_i,
    input  logic [num_reasons_p-1:0] stall_reason_i,
    input  logic                     clear_i,
    input  logic                     dump_i,
    output logic                     dump_v_o,
    input  logic                     dump_ready_i,
    output logic [idx_width_lp-1:0]  dump_idx_o,
    output logic [cnt_width_p-1:0]   dump_data_o,
    output logic                     busy_o
);

    localparam int num_ctr_lp    = num_reasons_p + 2;
    localparam int commit_idx_lp = stall_idx_commit(num_reasons_p);
    localparam int cycle_idx_lp  = stall_idx_cycle(num_reasons_p);
    localparam int enc_width_lp  = (num_reasons_p > 1) ? $clog2(num_reasons_p) : 1;

    bp_stall_prof_state_e            state_d, state_q;
    logic [idx_width_lp-1:0]         dump_idx_d, dump_idx_q;

    logic [enc_width_lp-1:0]         enc_addr;
    logic                            enc_v;
    logic [enc_width_lp-1:0]         reason_idx;
    logic [num_ctr_lp-1:0]           ctr_en;
    logic                            ctr_clr;
    logic [num_ctr_lp-1:0][cnt_width_p-1:0] ctr_cnt;

    bsg_priority_encode #(
        .width_p    (num_reasons_p),
        .lo_to_hi_p (1'b0)
    ) reason_enc (
        .i      (stall_reason_i),
        .addr_o (enc_addr),
        .v_o    (enc_v)
    );

    // No cause flagged means the stall is attributed to "unknown".
    assign reason_idx = enc_v ? enc_addr : enc_width_lp'(stall_idx_unknown_gp);

    always_comb begin
        state_d    = state_q;
        dump_idx_d = dump_idx_q;
        unique case (state_q)
            e_run: begin
                if (clear_i) begin
                    state_d = e_clear;
                end else if (dump_i) begin
                    state_d    = e_dump;
                    dump_idx_d = '0;
                end
            end
            e_dump: begin
                if (dump_ready_i) begin
                    if (dump_idx_q == idx_width_lp'(cycle_idx_lp)) begin
                        state_d    = e_run;
                        dump_idx_d = '0;
                    end else begin
                        dump_idx_d = dump_idx_q + 1'b1;
                    end
                end
            end
            e_clear: state_d = e_run;
            default: state_d = e_run;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q    <= e_run;
            dump_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            dump_idx_q <= dump_idx_d;
        end
    end

    // Only e_run counts; e_dump freezes, e_clear zeroes and drops the cycle.
    always_comb begin
        ctr_en = '0;
        if (state_q == e_run) begin
            ctr_en[cycle_idx_lp] = 1'b1;
            if (commit_v_i) ctr_en[commit_idx_lp] = 1'b1;
            else            ctr_en[reason_idx]    = 1'b1;
        end
    end

    assign ctr_clr = (state_q == e_clear);

    for (genvar g = 0; g < num_ctr_lp; g++) begin : g_ctr
        bp_nonsynth_sat_counter #(
            .width_p (cnt_width_p)
        ) ctr (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .clear_i   (ctr_clr),
            .en_i      (ctr_en[g]),
            .count_o   (ctr_cnt[g])
        );
    end

    assign dump_v_o    = (state_q == e_dump);
    assign busy_o      = (state_q != e_run);
    assign dump_idx_o  = dump_idx_q;
    assign dump_data_o = dump_v_o ? ctr_cnt[dump_idx_q] : '0;

endmodule

// File: tb/tb_bp_nonsynth_stall_profile_ctrl.sv
module tb_bp_nonsynth_stall_profile_ctrl;

    logic        clk;
    logic        reset_n;
    logic        commit_v;
    logic [9:0]  stall_reason;
    logic        clear;
    logic        dump;
    logic        dump_ready;

    logic        dump_v_w,   dump_v_n;
    logic [3:0]  dump_idx_w, dump_idx_n;
    logic [31:0] dump_data_w;
    logic [3:0]  dump_data_n;
    logic        busy_w,     busy_n;

    int total = 0;
    int bad   = 0;

    // Expected counter values at each dump, index 0..11.
    int exp_tbl [5][12] = '{
        '{0, 0, 5, 0, 0, 0, 0, 0, 0, 0,  3,  8},  // 5 stalls on bit 2, 3 commits
        '{1, 0, 5, 0, 0, 0, 0, 0, 0, 1,  3, 10},  // + one multi-hot stall, one unknown
        '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1,  1},  // after clear: one commit cycle
        '{0, 0, 0, 7, 0, 0, 0, 0, 0, 0,  0,  7},  // after reset mid-dump: 7 stalls on bit 3
        '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 20, 20}   // 20 commits (narrow copy saturates)
    };

    bp_nonsynth_stall_profile_ctrl #(.num_reasons_p(10), .cnt_width_p(32)) dut_w (
        .clk_i(clk), .reset_n_i(reset_n), .commit_v_i(commit_v),
        .stall_reason_i(stall_reason), .clear_i(clear), .dump_i(dump),
        .dump_v_o(dump_v_w), .dump_ready_i(dump_ready), .dump_idx_o(dump_idx_w),
        .dump_data_o(dump_data_w), .busy_o(busy_w)
    );

    bp_nonsynth_stall_profile_ctrl #(.num_reasons_p(10), .cnt_width_p(4)) dut_n (
        .clk_i(clk), .reset_n_i(reset_n), .commit_v_i(commit_v),
        .stall_reason_i(stall_reason), .clear_i(clear), .dump_i(dump),
        .dump_v_o(dump_v_n), .dump_ready_i(dump_ready), .dump_idx_o(dump_idx_n),
        .dump_data_o(dump_data_n), .busy_o(busy_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cap15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Drive one input pattern for n cycles; optionally raise dump_i on the last.
    task automatic run(input logic [9:0] rsn, input logic cmt, input int n, input bit dump_last);
        for (int i = 0; i < n; i++) begin
            stall_reason = rsn;
            commit_v     = cmt;
            dump         = dump_last && (i == n - 1);
            @(negedge clk);
        end
    endtask

    // Entered on the negedge right after dump_i was sampled.
    task automatic do_dump(input int scn, input bit toggle, input bit cmt_in_dump);
        int         nxt = 0;
        int         k   = 0;
        int         cyc = 0;
        bit         held = 0;
        bit         rdy;
        logic [3:0]  pidx;
        logic [31:0] pdata;
        dump         = 1'b0;
        stall_reason = '0;
        commit_v     = cmt_in_dump;
        chk("first_beat_busy", busy_w, 1);
        while (nxt < 12 && cyc < 200) begin
            if (!dump_v_w) begin
                chk("beat_valid", dump_v_w, 1);
                break;
            end
            if (held) begin
                chk("hold_idx",  dump_idx_w,  pidx);
                chk("hold_data", dump_data_w, pdata);
            end
            rdy = toggle ? (k % 3 == 0) : 1'b1;
            k++;
            dump_ready = rdy;
            if (rdy) begin
                chk($sformatf("s%0d_idx", scn), dump_idx_w, nxt);
                chk($sformatf("s%0d_data%0d", scn, nxt), dump_data_w, exp_tbl[scn][nxt]);
                chk($sformatf("s%0d_ndata%0d", scn, nxt), dump_data_n, cap15(exp_tbl[scn][nxt]));
                nxt++;
            end
            held  = !rdy;
            pidx  = dump_idx_w;
            pdata = dump_data_w;
            @(negedge clk);
            cyc++;
        end
        if (nxt < 12) chk("dump_complete", nxt, 12);
        if (!toggle) chk("consecutive_beats", cyc, 12);
        dump_ready = 1'b0;
        commit_v   = 1'b0;
        chk("post_dump_v",    dump_v_w, 0);
        chk("post_dump_busy", busy_w,   0);
        chk("post_dump_data", dump_data_w, 0);
    endtask

    initial begin
        int budget;
        reset_n = 0; commit_v = 0; stall_reason = '0; clear = 0; dump = 0; dump_ready = 0;
        repeat (3) @(negedge clk);
        chk("rst_v",    dump_v_w,    0);
        chk("rst_busy", busy_w,      0);
        chk("rst_idx",  dump_idx_w,  0);
        chk("rst_data", dump_data_w, 0);

        // Scenario 0: 5 stalls on bit 2, 3 commits, dump at full rate.
        reset_n = 1;
        run(10'b0000000100, 1'b0, 5, 0);
        run(10'b0000000000, 1'b1, 3, 1);
        do_dump(0, 0, 0);

        // Scenario 1: multi-hot picks bit 9, empty picks unknown; throttled dump with commits.
        run(10'b1000000110, 1'b0, 1, 0);
        run(10'b0000000000, 1'b0, 1, 1);
        do_dump(1, 1, 1);

        // Scenario 2: clear and dump together -> clear wins, single busy cycle.
        clear = 1; dump = 1;
        @(negedge clk);
        clear = 0; dump = 0;
        chk("clr_busy1", busy_w,   1);
        chk("clr_v1",    dump_v_w, 0);
        @(negedge clk);
        chk("clr_busy2", busy_w,   0);
        chk("clr_v2",    dump_v_w, 0);
        run(10'b0000000000, 1'b1, 1, 1);
        do_dump(2, 0, 0);

        // Scenario 3: reset at beat 4 aborts the stream.
        run(10'b0000000000, 1'b0, 1, 1);
        dump = 0;
        dump_ready = 1;
        budget = 0;
        while (!(dump_v_w && dump_idx_w == 4'd4) && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 50) chk("reach_beat4", budget, 0);
        reset_n = 0;
        @(negedge clk);
        dump_ready = 0;
        chk("abort_v",    dump_v_w,    0);
        chk("abort_busy", busy_w,      0);
        chk("abort_idx",  dump_idx_w,  0);
        chk("abort_data", dump_data_w, 0);
        reset_n = 1;
        run(10'b0000001000, 1'b0, 7, 1);
        do_dump(3, 0, 0);

        // Scenario 4: 20 commits; 4-bit copy saturates at 15.
        reset_n = 0;
        @(negedge clk);
        reset_n = 1;
        run(10'b0000000000, 1'b1, 20, 1);
        do_dump(4, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
